// File: rtl/rtc_bus_responder.sv
// Stand-in for the external RTC chip on the multiplexed a_d/cs/rd/wr bus: BCD clock/calendar plus countdown timer.
// Define RTC_BUS_SYNC_EN to pass a_d/cs/rd/wr through 2-FF synchronisers (all bus latencies +2 cycles).
module rtc_bus_responder #(
    parameter int TICK_DIV = 100000000,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_d,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    inout  wire  [ADDR_W-1:0] dato,
    output logic              irq
);
    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [7:0] A_CTRL  = 8'h00;
    localparam logic [7:0] A_STAT  = 8'h01;
    localparam logic [7:0] A_SEC   = 8'h21;
    localparam logic [7:0] A_MIN   = 8'h22;
    localparam logic [7:0] A_HOUR  = 8'h23;
    localparam logic [7:0] A_DAY   = 8'h24;
    localparam logic [7:0] A_MON   = 8'h25;
    localparam logic [7:0] A_YEAR  = 8'h26;
    localparam logic [7:0] A_WDAY  = 8'h27;
    localparam logic [7:0] A_TSEC  = 8'h41;
    localparam logic [7:0] A_TMIN  = 8'h42;
    localparam logic [7:0] A_THOUR = 8'h43;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic is_leap(input logic [7:0] y);
        return (!y[4] && (y[3:0] == 4'd0 || y[3:0] == 4'd4 || y[3:0] == 4'd8)) ||
               ( y[4] && (y[3:0] == 4'd2 || y[3:0] == 4'd6));
    endfunction

    // ---------------- bus input conditioning ----------------
    logic ad_in, cs_in, rd_in, wr_in;

`ifdef RTC_BUS_SYNC_EN
    logic [1:0] ad_sync, cs_sync, rd_sync, wr_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ad_sync <= 2'b00;
            cs_sync <= 2'b11;
            rd_sync <= 2'b11;
            wr_sync <= 2'b11;
        end else begin
            ad_sync <= {ad_sync[0], a_d};
            cs_sync <= {cs_sync[0], cs};
            rd_sync <= {rd_sync[0], rd};
            wr_sync <= {wr_sync[0], wr};
        end
    end

    assign ad_in = ad_sync[1];
    assign cs_in = cs_sync[1];
    assign rd_in = rd_sync[1];
    assign wr_in = wr_sync[1];
`else
    assign ad_in = a_d;
    assign cs_in = cs;
    assign rd_in = rd;
    assign wr_in = wr;
`endif

    logic ad_q, cs_q, rd_q, wr_q, rd_p, wr_p;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ad_q <= 1'b0;
            cs_q <= 1'b1;
            rd_q <= 1'b1;
            wr_q <= 1'b1;
            rd_p <= 1'b1;
            wr_p <= 1'b1;
        end else begin
            ad_q <= ad_in;
            cs_q <= cs_in;
            rd_q <= rd_in;
            wr_q <= wr_in;
            rd_p <= rd_q;
            wr_p <= wr_q;
        end
    end

    logic wr_rise, addr_wr, data_wr, rd_fall;
    assign wr_rise = wr_q & ~wr_p & ~cs_q;
    assign addr_wr = wr_rise & ~ad_q;
    assign data_wr = wr_rise &  ad_q;
    assign rd_fall = ~rd_q & rd_p & ~cs_q & ad_q;

    // ---------------- one-second prescaler ----------------
    logic [PW-1:0] presc;
    logic          presc_wrap, tick_pending, tick_apply;

    assign presc_wrap = (presc == PRESC_MAX);
    // Ticks wait for an idle bus so a register never changes under an access.
    assign tick_apply = tick_pending & cs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc        <= '0;
            tick_pending <= 1'b0;
        end else begin
            presc        <= presc_wrap ? '0 : presc + 1'b1;
            tick_pending <= presc_wrap | (tick_pending & ~cs_q);
        end
    end

    // ---------------- register file ----------------
    logic [7:0] addr;
    logic [7:0] sec, min, hour, day, mon, year, wday;
    logic [7:0] tsec, tmin, thour;
    logic       run, halt, expired;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       addr <= 8'h00;
        else if (addr_wr) addr <= dato;
    end

    logic [7:0] month_len;
    always_comb begin
        month_len = 8'h31;
        case (mon)
            8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
            8'h02:                      month_len = is_leap(year) ? 8'h29 : 8'h28;
            default:                    month_len = 8'h31;
        endcase
    end

    logic [7:0] sec_inc, min_inc, hour_inc, day_inc, mon_inc, year_inc, wday_inc;
    logic       sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap, year_wrap, wday_wrap;
    logic       c_min, c_hour, c_mon, c_year;

    assign sec_inc   = bcd_inc(sec);
    assign min_inc   = bcd_inc(min);
    assign hour_inc  = bcd_inc(hour);
    assign day_inc   = bcd_inc(day);
    assign mon_inc   = bcd_inc(mon);
    assign year_inc  = bcd_inc(year);
    assign wday_inc  = bcd_inc(wday);

    assign sec_wrap  = sec_inc  >= 8'h60;
    assign min_wrap  = min_inc  >= 8'h60;
    assign hour_wrap = hour_inc >= 8'h24;
    assign day_wrap  = day_inc  >  month_len;
    assign mon_wrap  = mon_inc  >  8'h12;
    assign year_wrap = year_inc >= 8'hA0;
    assign wday_wrap = wday_inc >  8'h07;

    assign c_min  = sec_wrap;
    assign c_hour = c_min  & min_wrap;
    assign c_mon  = c_hour & hour_wrap & day_wrap;
    assign c_year = c_mon  & mon_wrap;

    logic       timer_nz, tsec_borrow, tmin_borrow, timer_zero_nx;
    logic [7:0] tsec_nx, tmin_nx, thour_nx;

    assign timer_nz      = |{tsec, tmin, thour};
    assign tsec_borrow   = (tsec == 8'h00);
    assign tmin_borrow   = tsec_borrow & (tmin == 8'h00);
    assign tsec_nx       = tsec_borrow ? 8'h59 : bcd_dec(tsec);
    assign tmin_nx       = tmin_borrow ? 8'h59 : (tsec_borrow ? bcd_dec(tmin) : tmin);
    assign thour_nx      = tmin_borrow ? bcd_dec(thour) : thour;
    assign timer_zero_nx = (tsec_nx == 8'h00) && (tmin_nx == 8'h00) && (thour_nx == 8'h00);

    // Bus writes and ticks are mutually exclusive: writes need cs_q low, ticks need cs_q high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec     <= 8'h00;
            min     <= 8'h00;
            hour    <= 8'h00;
            day     <= 8'h01;
            mon     <= 8'h01;
            year    <= 8'h00;
            wday    <= 8'h00;
            tsec    <= 8'h00;
            tmin    <= 8'h00;
            thour   <= 8'h00;
            run     <= 1'b0;
            halt    <= 1'b0;
            expired <= 1'b0;
        end else if (data_wr) begin
            case (addr)
                A_CTRL: begin
                    run  <= dato[0];
                    halt <= dato[1];
                end
                A_STAT:  expired <= 1'b0;
                A_SEC:   sec     <= dato;
                A_MIN:   min     <= dato;
                A_HOUR:  hour    <= dato;
                A_DAY:   day     <= dato;
                A_MON:   mon     <= dato;
                A_YEAR:  year    <= dato;
                A_WDAY:  wday    <= dato;
                A_TSEC:  tsec    <= dato;
                A_TMIN:  tmin    <= dato;
                A_THOUR: thour   <= dato;
                default: ;
            endcase
        end else if (tick_apply) begin
            if (!halt) begin
                sec <= sec_wrap ? 8'h00 : sec_inc;
                if (c_min) min <= min_wrap ? 8'h00 : min_inc;
                if (c_hour) begin
                    hour <= hour_wrap ? 8'h00 : hour_inc;
                    if (hour_wrap) begin
                        day  <= day_wrap  ? 8'h01 : day_inc;
                        wday <= wday_wrap ? 8'h01 : wday_inc;
                    end
                end
                if (c_mon)  mon  <= mon_wrap  ? 8'h01 : mon_inc;
                if (c_year) year <= year_wrap ? 8'h00 : year_inc;
            end
            if (run && timer_nz) begin
                tsec  <= tsec_nx;
                tmin  <= tmin_nx;
                thour <= thour_nx;
                if (timer_zero_nx) expired <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq <= 1'b1;
        else        irq <= ~expired;
    end

    // ---------------- read path ----------------
    logic [7:0] rd_data, rd_buf;
    logic       oe;

    // NOTE: default assigned first so no path through the case leaves rd_data unassigned (no latch).
    always_comb begin
        rd_data = 8'h00;
        case (addr)
            A_CTRL:  rd_data = {6'b0, halt, run};
            A_STAT:  rd_data = {7'b0, expired};
            A_SEC:   rd_data = sec;
            A_MIN:   rd_data = min;
            A_HOUR:  rd_data = hour;
            A_DAY:   rd_data = day;
            A_MON:   rd_data = mon;
            A_YEAR:  rd_data = year;
            A_WDAY:  rd_data = wday;
            A_TSEC:  rd_data = tsec;
            A_TMIN:  rd_data = tmin;
            A_THOUR: rd_data = thour;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oe     <= 1'b0;
            rd_buf <= 8'h00;
        end else if (rd_q || cs_q) begin
            oe <= 1'b0;
        end else if (rd_fall) begin
            rd_buf <= rd_data;
            oe     <= 1'b1;
        end
    end

    assign dato = oe ? rd_buf : 'z;

endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Behavioural and synthesisable responder for the multiplexed a_d/cs/rd/wr RTC bus. It stands in for the external RTC chip on the FPGA so the RTC controller can be run in simulation and on the board without the real device.
- Holds a BCD timekeeping register file and a BCD countdown timer. Decodes address and data phases and drives the bidirectional data bus on reads.
- Sits on the far end of the `dato` bus, opposite the RTC controller.

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second tick. Must be ≥ 2.
- ADDR_W, 8: width of the address and data bus. Fixed at 8; must not be changed.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- a_d  in  1  0 = address phase, 1 = data phase
- cs  in  1  chip select, active low
- rd  in  1  read strobe, active low
- wr  in  1  write strobe, active low
- dato  inout  8  multiplexed address/data bus; driven by this block only during reads
- irq  out  1  timer-expired flag, active low

Behaviour:
- Reset (reset=0, async):
  - All time/date/timer registers = 0x00, except day = 0x01 and month = 0x01.
  - Control = 0x00, irq = 1, dato = Z, address latch = 0x00, prescaler = 0, tick_pending = 0.
- Bus sampling: a_d/cs/rd/wr are sampled on each clk rising edge. The previous sample is kept for edge detection.
- Address phase: wr rising edge (0→1) while sampled cs=0 and a_d=0 → latch dato into address register.
- Data write: wr rising edge while cs=0 and a_d=1 → write dato to the register at the latched address. Writes to unmapped addresses are ignored.
- Data read:
  - The cycle after rd is sampled falling while cs=0 and a_d=1, snapshot the register at the latched address into rd_buf and assert the output enable.
  - dato = rd_buf while oe=1.
  - oe clears the cycle after rd or cs is sampled high. Bus latency is 1 cycle each way.
  - Unmapped addresses read 0x00.
- Register map (BCD):
  - 0x21 seconds 00–59
  - 0x22 minutes 00–59
  - 0x23 hours 00–23
  - 0x24 day 01–(month length)
  - 0x25 month 01–12
  - 0x26 year 00–99
  - 0x27 weekday 01–07
  - 0x41 timer seconds, 0x42 timer minutes, 0x43 timer hours
  - 0x00 control: bit0 timer_run, bit1 clock_halt; reads {6'b0, halt, run}
  - 0x01 status: bit0 = expired flag; any write clears it
- Tick generation:
  - The prescaler counts 0..TICK_DIV-1 and wraps. The wrap sets tick_pending.
  - tick_pending is applied on the first cycle in which cs is sampled high. Ticks are therefore deferred during a transaction and never applied mid-access.
  - Multiple wraps during one transaction still collapse to a single tick.
- Applying a tick:
  - Time advance, when halt=0:
    - seconds+1; 59→00 carries into minutes.
    - minutes 59→00 carries into hours.
    - hours 23→00 carries into day and weekday.
    - weekday 07→01.
    - day at month length → 01, carries into month.
    - month 12→01, carries into year.
    - year 99→00.
  - Timer, when run=1:
    - If the timer is nonzero, decrement by one second with BCD borrow: seconds 00→59 borrows from minutes, minutes 00→59 borrows from hours.
    - The transition to 00:00:00 sets expired.
    - If the timer is already 00:00:00, it stays there and expired is not re-set.
- BCD increment rule: if units ≥ 9 then units=0, tens+1; otherwise units+1. After incrementing, any value ≥ the limit (or > the limit for 1-based registers) wraps to the minimum and carries. Out-of-range written values therefore wrap on their next tick.
- Month length:
  - 31 for months 01, 03, 05, 07, 08, 10, 12.
  - 30 for months 04, 06, 09, 11.
  - February is 29 if the year is a leap year, otherwise 28.
  - Leap-year test (on the BCD year): (tens even and units ∈ {0,4,8}) or (tens odd and units ∈ {2,6}).
- Write vs tick in the same cycle: cannot occur, because ticks only apply while cs is high.
- irq = ~expired, registered.
- Reset mid-transaction: oe drops immediately (async) and the pending tick is lost.

Optional Feature:
- RTC_BUS_SYNC_EN: when defined, a_d/cs/rd/wr pass through 2-FF synchronisers before sampling. All bus latencies grow by 2 cycles; dato is still sampled directly at the detected wr edge.
- When undefined, the inputs are sampled directly, which assumes they are driven from the same clk.

Test Plan:
- Reset, then read addresses 0x21–0x27 → values 00,00,00,01,01,00,00; dato = Z outside reads; irq = 1.
- TICK_DIV=4; write 0x21=0x59, 0x22=0x59, 0x23=0x23, 0x24=0x31, 0x25=0x12, 0x26=0x99, 0x27=0x07; after one tick read all → 00,00,00,01,01,00,01.
- Year=0x24, month=0x02, day=0x28, time 23:59:59 → after one tick day=0x29; after a further 86400 ticks (or a preset to 23:59:59) → day=0x01, month=0x03. With year=0x23, 02-28 rolls directly to 03-01.
- Timer 0x00:00:02, control=0x01 → after 2 ticks timer=00:00:00 and irq=0; a third tick leaves it at 00; write 0x01 → irq=1.
- Hold cs=0 (address phase only) for 3×TICK_DIV cycles → seconds advance by exactly 1, on the cycle after cs rises.
- Read of unmapped address 0x55 → 0x00; write to 0x55 → no register changes.
